fma_result_drain: RTL and testbench
===================================

FMA_RESULT_DRAIN -- requirements
Module: fma_result_drain

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the number of result FIFO entries (power of 2, at least 2).
REQ-002 The parameter TAG_W SHALL default to 5 and set the width of the destination tag carried with each operation.
REQ-003 The port clock SHALL be an input, 1 bit wide, and the rising-edge clock for all state.
REQ-004 The port reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-005 The port iss_valid SHALL be an input, 1 bit wide, and signal that the issuer requests to launch one FMA operation.
REQ-006 The port iss_tag SHALL be an input, TAG_W bits wide, and carry the destination tag of the issued operation.
REQ-007 The port iss_ready SHALL be an output, 1 bit wide, and signal that issue is permitted this cycle.
REQ-008 The port in_valid SHALL be an input, 1 bit wide, and signal that the FMA pipe presents a completed result (its validout).
REQ-009 The port in_rec SHALL be an input, 33 bits wide, and carry the recoded-format single-precision result.
REQ-010 The port in_exc SHALL be an input, 5 bits wide, and carry the result's exception flags {NV,DZ,OF,UF,NX}.
REQ-011 The port out_valid SHALL be an output, 1 bit wide, and signal that the FIFO head is valid.
REQ-012 The port out_ready SHALL be an input, 1 bit wide, and signal that the writeback consumer accepts the head.
REQ-013 The port out_data SHALL be an output, 32 bits wide, and carry the IEEE-754 binary32 value of the head.
REQ-014 The port out_tag SHALL be an output, TAG_W bits wide, and carry the tag of the head.
REQ-015 The port out_exc SHALL be an output, 5 bits wide, and carry the exception flags of the head.
REQ-016 The port fflags SHALL be an output, 5 bits wide, and carry the sticky accumulated exception flags.
REQ-017 The port fflags_clr SHALL be an input, 1 bit wide, and clear the sticky flags.
REQ-018 The port overflow_err SHALL be an output, 1 bit wide, and be set sticky when a result arrives at a full FIFO.

Function
REQ-019 The block SHALL hold a tag FIFO of depth DEPTH, pushed on issue fire (iss_valid & iss_ready), so that tags pair with results in order.
REQ-020 The block SHALL keep an inflight counter that increments on issue fire, decrements on in_valid, and is unchanged when both occur in the same cycle.
REQ-021 iss_ready SHALL be 1 exactly when the result-FIFO count plus inflight is less than DEPTH, so that credit-based flow control never overruns the non-stallable FMA pipe.
REQ-022 On in_valid, the block SHALL push {convert(in_rec), in_exc, popped tag} into the result FIFO.
REQ-023 The result SHALL become visible on out_valid in the cycle after in_valid (1-cycle latency), with no combinational bypass.
REQ-024 A pop SHALL occur on out_valid & out_ready.
REQ-025 A simultaneous push and pop SHALL be legal at any count, including a full FIFO.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Conversion SHALL be defined on the fields s=in_rec[32], e=in_rec[31:23], f=in_rec[22:0].
REQ-028 A zero SHALL be e[8:6]==0 and SHALL produce output {s,31'h0}.
REQ-029 A special value SHALL be e[8:7]==2'b11; NaN when e[6]=1, Inf when e[6]=0.
REQ-030 NaN SHALL produce {s,8'hFF,f}, and Inf SHALL produce {s,8'hFF,23'h0}.
REQ-031 A subnormal SHALL be a non-zero value with e<130, and SHALL produce {s,8'h00,({1'b1,f[22:1]} >> ((1-e[4:0]) mod 32))[22:0]}.
REQ-032 A normal value SHALL produce {s,(e-129)[7:0],f}.
REQ-033 fflags SHALL OR in in_exc on every in_valid.
REQ-034 fflags_clr SHALL zero fflags, with a same-cycle in_valid taking priority so its flags survive the clear.
REQ-035 When in_valid arrives with the FIFO full and no pop, the result SHALL be dropped, the tag still popped, and overflow_err set until reset.

Reset
REQ-036 On reset, the FIFO pointers, count, inflight, fflags and overflow_err SHALL be cleared.
REQ-037 On reset, out_valid SHALL be 0 and iss_ready SHALL be 1 in the first cycle after reset.
REQ-038 FIFO data storage SHALL NOT be reset.
REQ-039 A reset mid-operation SHALL discard all inflight and queued results; the FMA pipe shares this reset.

Configuration
REQ-040 When the macro FMA_DRAIN_FLAGS_EN is defined, the sticky fflags register and fflags_clr SHALL behave as in REQ-033 and REQ-034.
REQ-041 When FMA_DRAIN_FLAGS_EN is undefined, fflags SHALL be tied to 5'h0 and fflags_clr SHALL be ignored, while out_exc per entry is still provided.

Verification
REQ-042 The bench SHALL issue tag 3, then drive in_valid with in_rec=33'h0_8000_0000 and in_exc=0, and check that out_valid is 1 the next cycle with out_data=32'h3F800000 and out_tag=3.
REQ-043 The bench SHALL drive in_rec=33'h0_3580_0000, 33'h0_4080_0000, 33'h0_C000_0000, 33'h0_E040_0000 and 33'h1_0000_0000, and check out_data=32'h00000001, 32'h00400000, 32'h7F800000, 32'h7FC00000 and 32'h80000000 respectively.
REQ-044 The bench SHALL issue with out_ready=0 until iss_ready falls, and check that exactly DEPTH=4 issues are accepted and iss_ready rises the cycle after the first pop.
REQ-045 The bench SHALL send results with in_exc=5'b00001, then 5'b10000, and assert fflags_clr together with a third result carrying in_exc=5'b00100, and check fflags=5'b10001 before the clear and 5'b00100 after it (with FMA_DRAIN_FLAGS_EN defined).
REQ-046 The bench SHALL hold out_ready=0 with the FIFO full and force in_valid, and check that overflow_err=1 persists, count stays 4, and the head is unchanged.
REQ-047 The bench SHALL assert reset with 2 inflight and 2 queued results, and check that out_valid=0, iss_ready=1 and later in_valid pulses are counted afresh.

Source files
------------

// File: rtl/fma_result_drain.sv
// Drains a non-stallable FMA pipe: pairs recoded binary32 results with issue tags,
// converts them to IEEE-754 and queues them. Optional sticky flags under FMA_DRAIN_FLAGS_EN.
module fma_result_drain #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [TAG_W-1:0] iss_tag,
    output logic             iss_ready,
    input  logic             in_valid,
    input  logic [32:0]      in_rec,
    input  logic [4:0]       in_exc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_exc,
    output logic [4:0]       fflags,
    input  logic             fflags_clr,
    output logic             overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]      data;
        logic [4:0]       exc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           r_res_mem [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];

    logic [PTR_W-1:0] r_res_wr, r_res_rd, r_tag_wr, r_tag_rd;
    logic [CNT_W-1:0] r_count, r_inflight;
    logic             r_overflow;

    logic             w_iss_fire, w_pop, w_full, w_push, w_drop, w_tag_pop;
    logic [CNT_W:0]   w_credits;
    logic [TAG_W-1:0] w_res_tag;

    // ---------------- recoded -> IEEE binary32 conversion ----------------
    logic        w_sign;
    logic [8:0]  w_exp;
    logic [22:0] w_frac;
    logic [4:0]  w_shamt;
    logic [22:0] w_sub_mant;
    logic [7:0]  w_norm_exp;
    logic [31:0] w_conv;

    assign w_sign     = in_rec[32];
    assign w_exp      = in_rec[31:23];
    assign w_frac     = in_rec[22:0];
    assign w_shamt    = 5'd1 - w_exp[4:0];
    assign w_sub_mant = {1'b1, w_frac[22:1]} >> w_shamt;
    // Recoded bias is 129 higher than IEEE; only the low 8 bits survive for normals.
    assign w_norm_exp = w_exp[7:0] - 8'd129;

    always_comb begin
        w_conv = {w_sign, w_norm_exp, w_frac};
        if (w_exp[8:6] == 3'b000) begin
            w_conv = {w_sign, 31'h0};
        end else if (w_exp[8:7] == 2'b11) begin
            w_conv = w_exp[6] ? {w_sign, 8'hFF, w_frac} : {w_sign, 8'hFF, 23'h0};
        end else if (w_exp < 9'd130) begin
            w_conv = {w_sign, 8'h00, w_sub_mant};
        end
    end

    // ---------------- flow control ----------------
    assign w_credits  = {1'b0, r_count} + {1'b0, r_inflight};
    assign iss_ready  = w_credits < (CNT_W + 1)'(DEPTH);
    assign w_iss_fire = iss_valid & iss_ready;

    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid & out_ready;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_push     = in_valid & (~w_full | w_pop);
    assign w_drop     = in_valid & w_full & ~w_pop;
    // A stray result with nothing in flight must not corrupt the tag pointers.
    assign w_tag_pop  = in_valid & (r_inflight != '0);
    assign w_res_tag  = r_tag_mem[r_tag_rd];

    assign out_data     = r_res_mem[r_res_rd].data;
    assign out_exc      = r_res_mem[r_res_rd].exc;
    assign out_tag      = r_res_mem[r_res_rd].tag;
    assign overflow_err = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_res_wr   <= '0;
            r_res_rd   <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)     r_res_wr <= r_res_wr + 1'b1;
            if (w_pop)      r_res_rd <= r_res_rd + 1'b1;
            if (w_iss_fire) r_tag_wr <= r_tag_wr + 1'b1;
            if (w_tag_pop)  r_tag_rd <= r_tag_rd + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case ({w_iss_fire, w_tag_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            r_overflow <= r_overflow | w_drop;
        end
    end

    // NOTE: storage arrays are deliberately left out of reset; the pointers and count
    // qualify every read, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (w_push)     r_res_mem[r_res_wr] <= '{data: w_conv, exc: in_exc, tag: w_res_tag};
        if (w_iss_fire) r_tag_mem[r_tag_wr] <= iss_tag;
    end

    // ---------------- sticky exception flags ----------------
`ifdef FMA_DRAIN_FLAGS_EN
    logic [4:0] r_fflags;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fflags <= 5'h0;
        end else if (in_valid) begin
            // A same-cycle result survives the clear.
            r_fflags <= (fflags_clr ? 5'h0 : r_fflags) | in_exc;
        end else if (fflags_clr) begin
            r_fflags <= 5'h0;
        end
    end

    assign fflags = r_fflags;
`else
    logic w_unused_fflags_clr;

    assign w_unused_fflags_clr = fflags_clr;
    assign fflags              = 5'h0;
`endif

endmodule

// File: tb/tb_fma_result_drain.sv
// Scoreboard bench for fma_result_drain: expected entries queued when results are driven,
// compared when the DUT presents them.
module tb_fma_result_drain;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_tag = '0;
    logic        iss_ready;
    logic        in_valid = 1'b0;
    logic [32:0] in_rec = '0;
    logic [4:0]  in_exc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [4:0]  out_exc;
    logic [4:0]  fflags;
    logic        fflags_clr = 1'b0;
    logic        overflow_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic [4:0]  exc;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] tag_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    logic [32:0] vec_rec [5] = '{33'h0_3580_0000, 33'h0_4080_0000, 33'h0_C000_0000,
                                 33'h0_E040_0000, 33'h1_0000_0000};
    logic [31:0] vec_exp [5] = '{32'h0000_0001, 32'h0040_0000, 32'h7F80_0000,
                                 32'h7FC0_0000, 32'h8000_0000};

`ifdef FMA_DRAIN_FLAGS_EN
    localparam logic [4:0] FLAGS_ACC = 5'b10001;
    localparam logic [4:0] FLAGS_CLR = 5'b00100;
`else
    localparam logic [4:0] FLAGS_ACC = 5'b00000;
    localparam logic [4:0] FLAGS_CLR = 5'b00000;
`endif

    fma_result_drain #(.DEPTH(4), .TAG_W(5)) dut (
        .clock(clock), .reset(reset),
        .iss_valid(iss_valid), .iss_tag(iss_tag), .iss_ready(iss_ready),
        .in_valid(in_valid), .in_rec(in_rec), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_exc(out_exc),
        .fflags(fflags), .fflags_clr(fflags_clr), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] t);
        iss_valid = 1'b1;
        iss_tag   = t;
        if (iss_ready) tag_q.push_back(t);
        tick();
        iss_valid = 1'b0;
    endtask

    // One-cycle result pulse; the expected entry is queued unless the DUT should drop it.
    task automatic push_result(input logic [32:0] rec, input logic [4:0] exc,
                               input logic [31:0] exp_data, input bit dropped);
        logic [4:0] t;
        in_valid = 1'b1;
        in_rec   = rec;
        in_exc   = exc;
        if (tag_q.size() != 0) begin
            t = tag_q.pop_front();
            if (!dropped) exp_q.push_back(exp_t'{data: exp_data, tag: t, exc: exc});
        end
        tick();
        in_valid = 1'b0;
        in_exc   = '0;
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 40) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_data, out_tag, out_exc} !== {e.data, e.tag, e.exc}) begin
                    n_fail++;
                    $display("FAIL %s entry: data/tag/exc got %h/%0d/%b want %h/%0d/%b",
                             name, out_data, out_tag, out_exc, e.data, e.tag, e.exc);
                end
            end
            tick();
            budget++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain end: left=%0d out_valid=%b want left=0 out_valid=0",
                     name, exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++;
        if ({out_valid, iss_ready, overflow_err, fflags} !== {1'b0, 1'b1, 1'b0, 5'h0}) begin
            n_fail++;
            $display("FAIL reset state: ov/ir/oe/ff got %b%b%b %b want 010 00000",
                     out_valid, iss_ready, overflow_err, fflags);
        end
    endtask

    task automatic test_latency();
        issue(5'd3);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency pre: out_valid got %b want 0", out_valid);
        end
        push_result(33'h0_8000_0000, 5'h0, 32'h3F80_0000, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_tag !== 5'd3) begin
            n_fail++;
            $display("FAIL latency: ov/data/tag got %b/%h/%0d want 1/3f800000/3",
                     out_valid, out_data, out_tag);
        end
        drain("latency");
    endtask

    task automatic test_convert();
        for (int i = 0; i < 5; i++) begin
            issue(5'(10 + i));
            push_result(vec_rec[i], 5'h0, vec_exp[i], 1'b0);
            drain("convert");
        end
    endtask

    task automatic test_credit();
        int         accepted = 0;
        logic [4:0] t = 5'd1;
        exp_t       e;
        out_ready = 1'b0;
        iss_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!iss_ready) break;
            iss_tag = t;
            tag_q.push_back(t);
            accepted++;
            tick();
            t++;
        end
        iss_valid = 1'b0;
        n_cmp++;
        if (accepted != 4) begin
            n_fail++;
            $display("FAIL credit accepted: got %0d want 4", accepted);
        end
        for (int i = 0; i < 4; i++) push_result(vec_rec[i], 5'h0, vec_exp[i], 1'b0);
        n_cmp++;
        if (iss_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL credit full: iss_ready/out_valid got %b/%b want 0/1", iss_ready, out_valid);
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e.data || out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL credit head: data/tag got %h/%0d want %h/%0d", out_data, out_tag, e.data, e.tag);
        end
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (iss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL credit reopen: iss_ready got %b want 1", iss_ready);
        end
        drain("credit");
    endtask

    // Issue and results overlap every cycle with the consumer always ready.
    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b spurious: out_valid got 1 want 0");
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL b2b entry: data/tag got %h/%0d want %h/%0d",
                                 out_data, out_tag, e.data, e.tag);
                    end
                end
            end
            n_cmp++;
            if (iss_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b iss_ready: got %b want 1", iss_ready);
            end
            iss_valid = (c < 6);
            iss_tag   = 5'(c + 1);
            in_valid  = (c > 0);
            in_rec    = vec_rec[(c + 4) % 5];
            if (in_valid) exp_q.push_back(exp_t'{data: vec_exp[(c + 4) % 5], tag: tag_q.pop_front(), exc: 5'h0});
            if (iss_valid && iss_ready) tag_q.push_back(iss_tag);
            tick();
        end
        iss_valid = 1'b0;
        in_valid  = 1'b0;
        drain("b2b");
    endtask

    task automatic test_flags();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        for (int i = 0; i < 3; i++) issue(5'(24 + i));
        push_result(33'h0_8000_0000, 5'b00001, 32'h3F80_0000, 1'b0);
        push_result(33'h0_8000_0000, 5'b10000, 32'h3F80_0000, 1'b0);
        n_cmp++;
        if (fflags !== FLAGS_ACC) begin
            n_fail++;
            $display("FAIL flags accumulate: got %b want %b", fflags, FLAGS_ACC);
        end
        fflags_clr = 1'b1;
        push_result(33'h0_8000_0000, 5'b00100, 32'h3F80_0000, 1'b0);
        fflags_clr = 1'b0;
        n_cmp++;
        if (fflags !== FLAGS_CLR) begin
            n_fail++;
            $display("FAIL flags clear priority: got %b want %b", fflags, FLAGS_CLR);
        end
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        n_cmp++;
        if (fflags !== 5'h0) begin
            n_fail++;
            $display("FAIL flags clear: got %b want 00000", fflags);
        end
        drain("flags");
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(5'(16 + i));
        for (int i = 0; i < 4; i++) push_result(vec_rec[i], 5'h0, vec_exp[i], 1'b0);
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow early: got %b want 0", overflow_err);
        end
        push_result(33'h0_8000_0000, 5'b00010, 32'h3F80_0000, 1'b1);
        n_cmp++;
        if (overflow_err !== 1'b1 || out_data !== exp_q[0].data || out_tag !== exp_q[0].tag
            || iss_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow set: oe/data/tag/ir got %b/%h/%0d/%b want 1/%h/%0d/0",
                     overflow_err, out_data, out_tag, iss_ready, exp_q[0].data, exp_q[0].tag);
        end
        repeat (3) tick();
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow sticky: got %b want 1", overflow_err);
        end
        drain("overflow");
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow after drain: got %b want 1", overflow_err);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(5'(20 + i));
        push_result(vec_rec[0], 5'h0, vec_exp[0], 1'b0);
        push_result(vec_rec[1], 5'h0, vec_exp[1], 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tag_q.delete();
        exp_q.delete();
        n_cmp++;
        if ({out_valid, iss_ready, overflow_err, fflags} !== {1'b0, 1'b1, 1'b0, 5'h0}) begin
            n_fail++;
            $display("FAIL mid reset: ov/ir/oe/ff got %b%b%b %b want 010 00000",
                     out_valid, iss_ready, overflow_err, fflags);
        end
        issue(5'd7);
        push_result(33'h0_4080_0000, 5'h0, 32'h0040_0000, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_tag !== 5'd7) begin
            n_fail++;
            $display("FAIL after reset pairing: ov/tag got %b/%0d want 1/7", out_valid, out_tag);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_convert();
        test_credit();
        test_back_to_back();
        test_flags();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
